// File: rtl/mux_scan_reader.sv
// mux_scan_reader: read side of the 8:1 bit-select multiplexer on the skin
// sensor lines. It walks the channel select 0..7, holds each address for
// SETTLE cycles and then samples the single mux output bit. The eight samples
// form one frame, which is offered downstream on a valid/ready handshake.
// The scan never stalls. A completed frame that cannot be published because
// the previous one is still unconsumed is dropped, and the sticky overrun
// flag records the drop.

module mux_scan_reader #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [2:0] sel,
    input  logic       din,
    output logic [7:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       overrun,
    input  logic       overrun_clr,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    // The settle counter runs 0..SETTLE-1, so 4 bits cover the full 1..15 range.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     r_state;
    logic [3:0] r_settleCnt;
    logic [2:0] r_sel;
    logic [7:0] r_shadow;
    logic [7:0] r_frame;
    logic       r_frameValid;
    logic       r_overrun;
    logic       r_busy;

    logic       w_lastChannel;
    logic       w_accept;
    logic       w_canPublish;
    logic [7:0] w_candidate;

    // Channel 7 closes a frame. Its bit comes straight from din because the
    // shadow register only takes that bit at the same clock edge.
    assign w_lastChannel = (r_sel == 3'd7);
    assign w_accept      = r_frameValid & frame_ready;
    assign w_canPublish  = ~r_frameValid | frame_ready;
    assign w_candidate   = {din, r_shadow[6:0]};

    // Scan sequencer: state, channel select, sample shadow, frame handshake and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settleCnt  <= 4'd0;
            r_sel        <= 3'd0;
            r_shadow     <= 8'd0;
            r_frame      <= 8'd0;
            r_frameValid <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // A consumed frame retires first. A publish in the same cycle overrides the retire below.
            if (w_accept) begin
                r_frameValid <= 1'b0;
            end
            // A clear is applied first so that a drop in the same cycle still sets the flag.
            if (overrun_clr) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_sel <= 3'd0;
                    if (en) begin
                        r_state     <= ST_SETTLE;
                        r_settleCnt <= 4'd0;
                        r_busy      <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (r_settleCnt == CNT_LAST) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_settleCnt <= r_settleCnt + 4'd1;
                    end
                end

                ST_SAMPLE: begin
                    r_shadow[r_sel] <= din;
                    if (w_lastChannel) begin
                        if (w_canPublish) begin
                            r_frame      <= w_candidate;
                            r_frameValid <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                    if (en) begin
                        r_sel       <= r_sel + 3'd1;
                        r_state     <= ST_SETTLE;
                        r_settleCnt <= 4'd0;
                    end else begin
                        r_sel    <= 3'd0;
                        r_shadow <= 8'd0;
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sel         = r_sel;
    assign frame       = r_frame;
    assign frame_valid = r_frameValid;
    assign overrun     = r_overrun;
    assign busy        = r_busy;

endmodule

// File: tb/tb_mux_scan_reader.sv
// tb_mux_scan_reader: directed bench for mux_scan_reader. The stimulus side
// pushes the frame it expects into a queue. A monitor pops and compares each
// frame at the moment the DUT hands it over. Inputs change on the falling
// edge, and outputs are read on the falling edge.

module tb_mux_scan_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance, default settle of 2
    logic       en0, ready0, ovclr0;
    logic [7:0] pat0;
    logic       din0;
    logic [2:0] sel0;
    logic [7:0] frame0;
    logic       valid0, ovr0, busy0;

    // Parameter edge instances
    logic       en1, ready1, ovclr1;
    logic [7:0] pat1;
    logic       din1;
    logic [2:0] sel1;
    logic [7:0] frame1;
    logic       valid1, ovr1, busy1;

    logic        en15, ready15, ovclr15;
    logic [7:0]  pat15;
    logic        din15;
    logic [2:0]  sel15;
    logic [7:0]  frame15;
    logic        valid15, ovr15, busy15;

    // Each sensor line is modelled as a fixed pattern indexed by the select the DUT drives.
    assign din0  = pat0[sel0];
    assign din1  = pat1[sel1];
    assign din15 = pat15[sel15];

    mux_scan_reader #(.SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .sel(sel0), .din(din0),
        .frame(frame0), .frame_valid(valid0), .frame_ready(ready0),
        .overrun(ovr0), .overrun_clr(ovclr0), .busy(busy0)
    );

    mux_scan_reader #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .sel(sel1), .din(din1),
        .frame(frame1), .frame_valid(valid1), .frame_ready(ready1),
        .overrun(ovr1), .overrun_clr(ovclr1), .busy(busy1)
    );

    mux_scan_reader #(.SETTLE(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .en(en15), .sel(sel15), .din(din15),
        .frame(frame15), .frame_valid(valid15), .frame_ready(ready15),
        .overrun(ovr15), .overrun_clr(ovclr15), .busy(busy15)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] expQ[$];

    // Counts one comparison and reports it when it miscompares.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sets the line pattern and the ready level of the main instance. It optionally queues the frame that the pattern must produce.
    task automatic applyStimulus(input logic [7:0] pattern, input logic ready, input logic expectFrame);
        pat0   = pattern;
        ready0 = ready;
        if (expectFrame) expQ.push_back(pattern);
    endtask

    // Waits a bounded number of cycles for the main instance to return to idle.
    task automatic waitIdle(input string name);
        int n = 0;
        while (busy0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(busy0), 32'd0);
    endtask

    // Holds the main instance idle for 50 cycles and checks that sel and busy never move.
    task automatic idleHold(input string name);
        int bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sel0 !== 3'd0 || busy0 !== 1'b0) bad++;
        end
        checkOutput(name, 32'(bad), 32'd0);
    endtask

    // Monitor: a frame is handed over when valid and ready are both high at the next rising edge.
    always begin
        @(negedge clk);
        #1;
        if (rst_n === 1'b1 && valid0 === 1'b1 && ready0 === 1'b1) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL scoreboard unexpected frame: got 0x%0h, expected none", frame0);
            end else begin
                logic [7:0] expFrame;
                expFrame = expQ.pop_front();
                checkOutput("scoreboard frame", 32'(frame0), 32'(expFrame));
            end
        end
    end

    // Guards against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad;
        int found;

        rst_n  = 1'b0;
        en0 = 1'b0; ready0 = 1'b0; ovclr0 = 1'b0; pat0 = 8'h00;
        en1 = 1'b0; ready1 = 1'b0; ovclr1 = 1'b0; pat1 = 8'h00;
        en15 = 1'b0; ready15 = 1'b0; ovclr15 = 1'b0; pat15 = 8'h00;

        // Reset state and an idle hold with en low
        repeat (2) @(negedge clk);
        checkOutput("reset sel", 32'(sel0), 32'd0);
        checkOutput("reset frame_valid", 32'(valid0), 32'd0);
        checkOutput("reset busy", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        idleHold("idle after reset");

        // Single frame A5 with ready held high
        applyStimulus(8'hA5, 1'b1, 1'b1);
        @(negedge clk);
        en0 = 1'b1;
        bad = 0;
        for (int j = 0; j <= 25; j++) begin
            @(negedge clk);
            if (j < 24 && sel0 !== 3'(j / 3)) bad++;
            if (j == 23) checkOutput("single valid before edge 25", 32'(valid0), 32'd0);
            if (j == 24) begin
                checkOutput("single valid at edge 25", 32'(valid0), 32'd1);
                checkOutput("single sel wraps to 0", 32'(sel0), 32'd0);
                en0 = 1'b0;
            end
            if (j == 25) checkOutput("single valid one-cycle pulse", 32'(valid0), 32'd0);
        end
        checkOutput("single sel sequence", 32'(bad), 32'd0);
        waitIdle("single back to idle");

        // Back-pressure: 3C is held while C3 is dropped
        applyStimulus(8'h3C, 1'b0, 1'b1);
        @(negedge clk);
        en0 = 1'b1;
        for (int j = 0; j <= 48; j++) begin
            @(negedge clk);
            if (j == 24) begin
                checkOutput("bp first frame valid", 32'(valid0), 32'd1);
                applyStimulus(8'hC3, 1'b0, 1'b0);
            end
            if (j == 47) checkOutput("bp overrun before drop", 32'(ovr0), 32'd0);
            if (j == 48) begin
                checkOutput("bp overrun set", 32'(ovr0), 32'd1);
                checkOutput("bp frame held", 32'(frame0), 32'h3C);
                checkOutput("bp valid held", 32'(valid0), 32'd1);
                en0 = 1'b0;
            end
        end
        waitIdle("bp back to idle");
        ready0 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        checkOutput("bp consumed", 32'(valid0), 32'd0);
        checkOutput("bp overrun sticky", 32'(ovr0), 32'd1);
        ovclr0 = 1'b1;
        @(negedge clk);
        ovclr0 = 1'b0;
        checkOutput("bp overrun cleared", 32'(ovr0), 32'd0);

        // Frame 2 publishes in the same cycle that frame 1 is accepted
        applyStimulus(8'h96, 1'b0, 1'b1);
        @(negedge clk);
        en0 = 1'b1;
        for (int j = 0; j <= 48; j++) begin
            @(negedge clk);
            if (j == 24) applyStimulus(8'h69, 1'b0, 1'b1);
            if (j == 47) ready0 = 1'b1;
            if (j == 48) begin
                checkOutput("simul valid stays", 32'(valid0), 32'd1);
                checkOutput("simul frame 2", 32'(frame0), 32'h69);
                checkOutput("simul no overrun", 32'(ovr0), 32'd0);
                en0 = 1'b0;
            end
        end
        waitIdle("simul back to idle");
        ready0 = 1'b0;

        // Stop mid-scan during the settle of channel 3
        applyStimulus(8'hFF, 1'b1, 1'b0);
        @(negedge clk);
        en0 = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            if (j == 9) begin
                checkOutput("stop sel at ch3", 32'(sel0), 32'd3);
                en0 = 1'b0;
            end
            if (j == 11) checkOutput("stop ch3 still busy", 32'(busy0), 32'd1);
            if (j == 12) begin
                checkOutput("stop sel to 0", 32'(sel0), 32'd0);
                checkOutput("stop busy low", 32'(busy0), 32'd0);
            end
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (valid0 !== 1'b0) bad++;
        end
        checkOutput("stop no frame", 32'(bad), 32'd0);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        en0 = 1'b1;
        for (int j = 0; j <= 24; j++) begin
            @(negedge clk);
            if (j == 24) begin
                checkOutput("restart frame valid", 32'(valid0), 32'd1);
                en0 = 1'b0;
            end
        end
        waitIdle("restart back to idle");
        ready0 = 1'b0;

        // Asynchronous reset while sel is 5 and the scan is settling
        applyStimulus(8'h5A, 1'b0, 1'b0);
        @(negedge clk);
        en0 = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (sel0 === 3'd5) found = 1;
        end
        checkOutput("reach sel 5", 32'(found), 32'd1);
        checkOutput("busy before reset", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        en0 = 1'b0;
        #1;
        checkOutput("async reset sel", 32'(sel0), 32'd0);
        checkOutput("async reset frame", 32'(frame0), 32'd0);
        checkOutput("async reset valid", 32'(valid0), 32'd0);
        checkOutput("async reset overrun", 32'(ovr0), 32'd0);
        checkOutput("async reset busy", 32'(busy0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idleHold("idle after mid-scan reset");

        // Settle of 1 (16-cycle frames) and settle of 15 (128-cycle frames)
        pat1 = 8'h5A; ready1 = 1'b1;
        pat15 = 8'hC3; ready15 = 1'b1;
        @(negedge clk);
        en1 = 1'b1;
        en15 = 1'b1;
        bad = 0;
        for (int j = 0; j <= 129; j++) begin
            @(negedge clk);
            if (j < 16 && sel1 !== 3'(j / 2)) bad++;
            if (j == 15) checkOutput("s1 valid before edge 17", 32'(valid1), 32'd0);
            if (j == 16) begin
                checkOutput("s1 valid at edge 17", 32'(valid1), 32'd1);
                checkOutput("s1 frame", 32'(frame1), 32'h5A);
            end
            if (j == 31) checkOutput("s1 valid before 2nd frame", 32'(valid1), 32'd0);
            if (j == 32) begin
                checkOutput("s1 second frame at period 16", 32'(valid1), 32'd1);
                en1 = 1'b0;
            end
            if (j == 15) checkOutput("s15 sel held", 32'(sel15), 32'd0);
            if (j == 16) checkOutput("s15 sel advances", 32'(sel15), 32'd1);
            if (j == 127) checkOutput("s15 valid before edge 129", 32'(valid15), 32'd0);
            if (j == 128) begin
                checkOutput("s15 valid at edge 129", 32'(valid15), 32'd1);
                checkOutput("s15 frame", 32'(frame15), 32'hC3);
                en15 = 1'b0;
            end
        end
        checkOutput("s1 sel sequence", 32'(bad), 32'd0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
